sram_wb_bridge: RTL and testbench
=================================

SRAM_WB_BRIDGE -- requirements
Module: sram_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte base of the SRAM window.
REQ-003 SHALL have ports clk_i in 1 (the single clock for bus and SRAM port 0) and rst_ni in 1 (asynchronous, active-low reset).
REQ-004 SHALL have Wishbone ports wb_cyc_i in 1, wb_stb_i in 1, wb_we_i in 1, wb_sel_i in 4, wb_adr_i in 32, wb_dat_i in 32, wb_dat_o out 32, wb_ack_o out 1.
REQ-005 SHALL have SRAM port-0 ports sram_csb0 out 1, sram_web0 out 1, sram_wmask0 out 4, sram_addr0 out ADDR_WIDTH, sram_din0 out 32, sram_dout0 in 32.
REQ-006 SHALL have wb_err_o out 1, present only when SRAM_BRIDGE_ERR_EN is defined.

Function
REQ-007 All outputs SHALL be registered.
REQ-008 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE -> ISSUE when wb_cyc_i & wb_stb_i & !wb_ack_o; latch sram_csb0=0, sram_web0=!wb_we_i, sram_wmask0=wb_sel_i (writes) or 4'b0 (reads), sram_addr0=wb_adr_i[ADDR_WIDTH+1:2], sram_din0=wb_dat_i.
REQ-010 ISSUE: command is held for exactly one clk_i edge; at ISSUE exit, sram_csb0 returns to 1 and sram_web0 to 1.
REQ-011 ISSUE -> WAIT unconditionally; a write completes in the macro at the falling edge of WAIT.
REQ-012 WAIT -> RESP; on a read, wb_dat_o SHALL capture sram_dout0 at that edge.
REQ-013 RESP: wb_ack_o=1 for exactly one cycle, then -> IDLE; ack is the first cycle after request acceptance plus 3 (read and write identical).
REQ-014 wb_dat_o SHALL hold its last read value on writes and while idle.
REQ-015 wb_adr_i[1:0] SHALL be ignored; wb_sel_i=0 on a write SHALL still complete with ack and modify no byte.
REQ-016 If wb_cyc_i drops in ISSUE or WAIT, the SRAM access SHALL complete but wb_ack_o SHALL stay 0 and the FSM SHALL return to IDLE.
REQ-017 A new request SHALL NOT be accepted in the cycle wb_ack_o is high; back-to-back throughput is one transfer per 4 cycles.
REQ-018 No more than one SRAM command SHALL be outstanding; sram_csb0 low for exactly one cycle per accepted request.

Reset
REQ-019 rst_ni low SHALL asynchronously force IDLE, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0.
REQ-020 Reset asserted mid-transaction SHALL abandon it with no ack; deassertion is clocked into the FSM with no spurious SRAM command.

Configuration
REQ-021 With SRAM_BRIDGE_ERR_EN defined: a request whose wb_adr_i lies outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH) SHALL skip the SRAM (csb0 stays 1) and assert wb_err_o (not ack) for one cycle, 1 cycle after acceptance.
REQ-022 Without SRAM_BRIDGE_ERR_EN: wb_err_o is absent, upper address bits are ignored, and all requests alias into the SRAM.

Structure
REQ-023 FSM state encoding, default ADDR_WIDTH and BASE_ADDR constants SHALL live in shared package sram_bridge_pkg.
REQ-024 No sub-module; the block instantiates nothing and connects to the SRAM macro at the top level.

Verification
REQ-025 Write adr=0x3000_0010 dat=0xDEADBEEF sel=4'hF, then read same -> ack at cycle+3 each, wb_dat_o=0xDEADBEEF.
REQ-026 Write sel=4'b0101 dat=0x11223344 over 0xAAAAAAAA -> readback 0xAA22AA44.
REQ-027 Drop wb_cyc_i during WAIT -> no ack, csb0 pulsed exactly once, next request serviced normally.
REQ-028 rst_ni low during ISSUE -> outputs at reset values immediately, no ack; post-reset read returns correct data.
REQ-029 With SRAM_BRIDGE_ERR_EN, read adr=0x4000_0000 -> wb_err_o one cycle, wb_ack_o=0, sram_csb0 stays 1.
REQ-030 Four back-to-back reads of addresses 0..3 -> acks spaced exactly 4 cycles apart, data in order.

Source files
------------

// File: rtl/sram_bridge_pkg.sv
// Shared FSM encoding and default window constants for the SRAM Wishbone bridge.
package sram_bridge_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 8;
    localparam logic [31:0] SRAM_BASE_ADDR  = 32'h3000_0000;
    localparam int unsigned WB_DATA_WIDTH   = 32;
    localparam int unsigned WB_SEL_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave driving port 0 of a single-port SRAM macro, one fixed 4-cycle transfer at a time.
// Optional SRAM_BRIDGE_ERR_EN: requests outside the SRAM window answer with wb_err_o and never reach the macro.
module sram_wb_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = SRAM_BASE_ADDR
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic [31:0]              wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic                     wb_ack_o,
`ifdef SRAM_BRIDGE_ERR_EN
    output logic                     wb_err_o,
`endif
    output logic                     sram_csb0,
    output logic                     sram_web0,
    output logic [WB_SEL_WIDTH-1:0]  sram_wmask0,
    output logic [ADDR_WIDTH-1:0]    sram_addr0,
    output logic [WB_DATA_WIDTH-1:0] sram_din0,
    input  logic [WB_DATA_WIDTH-1:0] sram_dout0
);

    bridge_state_e state;
    logic          rd_q;
    logic          abort_q;
    logic          wb_req_c;
    logic          addr_ok_c;
    logic          unused_adr;

    assign wb_req_c   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

`ifdef SRAM_BRIDGE_ERR_EN
    // Window compare in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_LO = 33'(BASE_ADDR);
    localparam logic [32:0] WIN_HI = 33'(BASE_ADDR) + (33'(1) << (ADDR_WIDTH + 2));
    assign addr_ok_c = (33'(wb_adr_i) >= WIN_LO) && (33'(wb_adr_i) < WIN_HI);
`else
    assign addr_ok_c = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rd_q        <= 1'b0;
            abort_q     <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
`ifdef SRAM_BRIDGE_ERR_EN
            wb_err_o    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (wb_req_c) begin
                        if (addr_ok_c) begin
                            sram_csb0   <= 1'b0;
                            sram_web0   <= ~wb_we_i;
                            sram_wmask0 <= wb_we_i ? wb_sel_i : 4'b0000;
                            sram_addr0  <= wb_adr_i[ADDR_WIDTH+1:2];
                            sram_din0   <= wb_dat_i;
                            rd_q        <= ~wb_we_i;
                            abort_q     <= 1'b0;
                            state       <= ISSUE;
                        end
`ifdef SRAM_BRIDGE_ERR_EN
                        else begin
                            wb_err_o <= 1'b1;
                            state    <= RESP;
                        end
`endif
                    end
                end
                ISSUE: begin
                    // The macro has sampled the command; release it and remember a master drop.
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    abort_q   <= ~wb_cyc_i;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (abort_q || !wb_cyc_i) begin
                        state <= IDLE;
                    end else begin
                        wb_ack_o <= 1'b1;
                        if (rd_q) begin
                            wb_dat_o <= sram_dout0;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    wb_ack_o <= 1'b0;
`ifdef SRAM_BRIDGE_ERR_EN
                    wb_err_o <= 1'b0;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Directed bench for sram_wb_bridge: cycle-indexed expectation schedule plus a behavioural SRAM macro.
module tb_sram_wb_bridge;

    localparam int unsigned AW       = 8;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int unsigned NWORDS   = 256;

    typedef struct packed {
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  addr;
        logic [31:0] din;
    } cmd_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_ack_o;
`ifdef SRAM_BRIDGE_ERR_EN
    logic        wb_err_o;
`endif
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    sram_wb_bridge dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
`ifdef SRAM_BRIDGE_ERR_EN
        .wb_err_o   (wb_err_o),
`endif
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    always #5 clk_i = ~clk_i;

    int cnum = 0;
    always @(posedge clk_i) cnum <= cnum + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnum);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        merge = old;
        for (int b = 0; b < 4; b++) if (sel[b]) merge[8*b +: 8] = d[8*b +: 8];
    endfunction

    // Behavioural SRAM macro: command sampled on the rising edge, executed on the next falling edge.
    logic [31:0] sram_mem [NWORDS];
    logic        pend = 1'b0;
    logic        p_web;
    logic [3:0]  p_wmask;
    logic [AW-1:0] p_addr;
    logic [31:0] p_din;

    always @(posedge clk_i) begin
        pend    <= !sram_csb0;
        p_web   <= sram_web0;
        p_wmask <= sram_wmask0;
        p_addr  <= sram_addr0;
        p_din   <= sram_din0;
    end

    always @(negedge clk_i) begin
        if (pend) begin
            if (!p_web) sram_mem[p_addr] <= merge(sram_mem[p_addr], p_din, p_wmask);
            else        sram_dout0 <= sram_mem[p_addr];
        end
    end

    // Reference model: word array plus per-cycle expectations.
    logic [31:0] ref_mem [NWORDS];
    bit          ack_sched [int];
    bit          err_sched [int];
    logic [31:0] dat_upd   [int];
    cmd_t        cmd_sched [int];
    logic [31:0] exp_dat = 32'h0;
    int          free_cyc = 0;
    int          ack_q [$];

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (dat_upd.exists(cnum)) exp_dat = dat_upd[cnum];
            chk("ack", 32'(wb_ack_o), 32'(ack_sched.exists(cnum)));
            chk("csb0", 32'(sram_csb0), 32'(!cmd_sched.exists(cnum)));
            chk("dat_o", wb_dat_o, exp_dat);
            if (cmd_sched.exists(cnum) && sram_csb0 === 1'b0) begin
                chk("web0", 32'(sram_web0), 32'(cmd_sched[cnum].web));
                chk("wmask0", 32'(sram_wmask0), 32'(cmd_sched[cnum].wmask));
                chk("addr0", 32'(sram_addr0), 32'(cmd_sched[cnum].addr));
                chk("din0", sram_din0, cmd_sched[cnum].din);
            end
`ifdef SRAM_BRIDGE_ERR_EN
            chk("err", 32'(wb_err_o), 32'(err_sched.exists(cnum)));
`endif
            if (wb_ack_o === 1'b1) ack_q.push_back(cnum);
        end
    end

    task automatic sync_idle();
        while (cnum < free_cyc) @(negedge clk_i);
    endtask

    // Present one request and schedule what the bridge must do; returns on the negedge of its last cycle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit keep, input bit abort);
        int            acc;
        int            done_cyc;
        bit            in_rng;
        cmd_t          c;
        logic [AW-1:0] idx;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_adr_i = adr;
        wb_dat_i = dat;
        acc      = (cnum > free_cyc) ? cnum : free_cyc;
        idx      = adr[AW+1:2];
        in_rng   = 1'b1;
`ifdef SRAM_BRIDGE_ERR_EN
        in_rng = (longint'(adr) >= longint'(BASE)) && (longint'(adr) < longint'(BASE) + 64'd1024);
`endif
        if (!in_rng) begin
            err_sched[acc + 1] = 1'b1;
            free_cyc = acc + 2;
            done_cyc = acc + 1;
        end else begin
            c.web   = !we;
            c.wmask = we ? sel : 4'h0;
            c.addr  = idx;
            c.din   = dat;
            cmd_sched[acc + 1] = c;
            if (we) ref_mem[idx] = merge(ref_mem[idx], dat, sel);
            if (abort) begin
                free_cyc = acc + 3;
                done_cyc = acc + 2;
            end else begin
                ack_sched[acc + 3] = 1'b1;
                if (!we) dat_upd[acc + 3] = ref_mem[idx];
                free_cyc = acc + 4;
                done_cyc = acc + 3;
            end
        end
        while (cnum < done_cyc) @(negedge clk_i);
        if (!keep || abort || !in_rng) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            wb_we_i  = 1'b0;
        end
    endtask

    function automatic int last_ack();
        return (ack_q.size() > 0) ? ack_q[$] : -1000;
    endfunction

    initial begin
        int p;
        int m;
        int sz;
        int na;
        for (int i = 0; i < int'(NWORDS); i++) begin
            sram_mem[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i]  = 32'hC0DE_0000 | 32'(i);
        end
        sram_dout0 = 32'h0;
        rst_ni   = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        repeat (3) @(negedge clk_i);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_csb0", 32'(sram_csb0), 32'd1);
        chk("rst_web0", 32'(sram_web0), 32'd1);
        chk("rst_wmask0", 32'(sram_wmask0), 32'd0);
        chk("rst_addr0", 32'(sram_addr0), 32'd0);
        chk("rst_din0", sram_din0, 32'd0);
        chk("rst_dat_o", wb_dat_o, 32'd0);
        rst_ni   = 1'b1;
        free_cyc = cnum + 1;
        @(negedge clk_i);

        // Back-to-back reads of words 0..3 with cyc/stb held high throughout.
        sync_idle();
        sz = ack_q.size();
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, i < 3, 1'b0);
            #1 chk("b2b_data", wb_dat_o, 32'hC0DE_0000 | 32'(i));
        end
        if (ack_q.size() >= sz + 4) begin
            for (int i = 1; i < 4; i++)
                chk("b2b_spacing", 32'(ack_q[sz + i] - ack_q[sz + i - 1]), 32'd4);
        end else begin
            chk("b2b_ack_count", 32'(ack_q.size() - sz), 32'd4);
        end

        // Full write then read, each acked three cycles after acceptance.
        sync_idle();
        p = cnum;
        xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        #1 chk("wr_latency", 32'(last_ack() - p), 32'd3);
        chk("wr_holds_dat", wb_dat_o, 32'hC0DE_0003);
        sync_idle();
        p = cnum;
        xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("rd_latency", 32'(last_ack() - p), 32'd3);
        chk("rd_deadbeef", wb_dat_o, 32'hDEAD_BEEF);

        // Byte-lane offset ignored; an all-zero select write changes nothing.
        xfer(1'b0, 32'h3000_0013, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("rd_low_bits", wb_dat_o, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("sel0_write", wb_dat_o, 32'hDEAD_BEEF);

        // Partial-lane write over a known background.
        xfer(1'b1, 32'h3000_0020, 4'hF, 32'hAAAA_AAAA, 1'b0, 1'b0);
        xfer(1'b1, 32'h3000_0020, 4'b0101, 32'h1122_3344, 1'b0, 1'b0);
        xfer(1'b0, 32'h3000_0020, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("mask_readback", wb_dat_o, 32'hAA22_AA44);

        // Master abandons a write in WAIT: no ack, the write still lands, next request is normal.
        sync_idle();
        na = ack_q.size();
        xfer(1'b1, 32'h3000_0030, 4'hF, 32'h5A5A_1234, 1'b0, 1'b1);
        repeat (2) @(negedge clk_i);
        #1 chk("abort_no_ack", 32'(ack_q.size() - na), 32'd0);
        xfer(1'b0, 32'h3000_0030, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("abort_readback", wb_dat_o, 32'h5A5A_1234);

        // Reset asserted while the bridge holds a read command.
        sync_idle();
        m = cnum;
        na = ack_q.size();
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_adr_i = 32'h3000_0010;
        wb_dat_i = 32'h0;
        cmd_sched[m + 1] = '{web: 1'b1, wmask: 4'h0, addr: 8'h04, din: 32'h0};
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_csb0", 32'(sram_csb0), 32'd1);
        chk("mid_rst_web0", 32'(sram_web0), 32'd1);
        chk("mid_rst_addr0", 32'(sram_addr0), 32'd0);
        chk("mid_rst_ack", 32'(wb_ack_o), 32'd0);
        chk("mid_rst_dat_o", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        ack_sched.delete();
        dat_upd.delete();
        cmd_sched.delete();
        exp_dat = 32'h0;
        repeat (2) @(negedge clk_i);
        chk("rst_held_csb0", 32'(sram_csb0), 32'd1);
        rst_ni   = 1'b1;
        free_cyc = cnum + 1;
        repeat (3) @(negedge clk_i);
        #1 chk("rst_no_ack", 32'(ack_q.size() - na), 32'd0);
        xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("post_rst_read", wb_dat_o, 32'hDEAD_BEEF);

`ifdef SRAM_BRIDGE_ERR_EN
        // Out-of-window requests error without touching the macro.
        na = ack_q.size();
        xfer(1'b0, 32'h4000_0000, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("err_lit", 32'(wb_err_o), 32'd1);
        xfer(1'b0, 32'h3000_0400, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("err_top_edge", 32'(wb_err_o), 32'd1);
        chk("err_no_ack", 32'(ack_q.size() - na), 32'd0);
        xfer(1'b0, 32'h3000_03FC, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("last_word", wb_dat_o, 32'hC0DE_00FF);
`else
        // Upper address bits alias into the SRAM.
        xfer(1'b0, 32'h4000_0010, 4'hF, 32'h0, 1'b0, 1'b0);
        #1 chk("alias_read", wb_dat_o, 32'hDEAD_BEEF);
`endif

        repeat (4) @(negedge clk_i);
        chk("mem_mask_word", sram_mem[8], 32'hAA22_AA44);
        chk("mem_abort_word", sram_mem[12], 32'h5A5A_1234);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
